// File: rtl/ov_frame_source.sv
// ov_frame_source: replays an RGB332 frame (frame buffer or test pattern) as an
// OV7670-style RGB565 byte stream with HREF/VSYNC framing, one byte per PCLK.
module ov_frame_source #(
    parameter int unsigned H_ACTIVE    = 176,
    parameter int unsigned V_ACTIVE    = 144,
    parameter int unsigned H_BLANK     = 16,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 2,
    parameter int unsigned V_FRONT     = 2,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              TEST_PAT,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [7:0]        RD_DATA,
    output logic [7:0]        DATA_OUT,
    output logic              HREF_OUT,
    output logic              VSYNC_OUT,
    output logic              FRAME_DONE
);

    localparam int unsigned L         = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HREF_LEN  = 2 * H_ACTIVE;
    localparam int unsigned MAX_A     = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int unsigned MAX_B     = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int unsigned MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned H_W       = $clog2(L + 1);
    localparam int unsigned LINE_W    = $clog2(MAX_LINES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [H_W-1:0]      h_q, h_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                tp_q, tp_d;
    logic [7:0]          pix_q, pix_d;
    logic [7:0]          data_q, data_d;
    logic                href_q, href_d;
    logic                vsync_q, vsync_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0]   last_line;
    logic [H_W-1:0]      col;
    logic [15:0]         rgb;
    logic                active_d;

    // RGB332 -> RGB565 by bit replication
    function automatic logic [15:0] rgb565(input logic [7:0] p);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = p[7:5];
        g = p[4:2];
        b = p[1:0];
        return {r, r[2:1], g, g, b, b, b[1]};
    endfunction

    // Number of the final line period of the current state
    always_comb begin
        last_line = '0;
        case (state_q)
            S_VSYNC:  last_line = LINE_W'(VSYNC_LINES - 1);
            S_VBACK:  last_line = LINE_W'(V_BACK - 1);
            S_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
            S_VFRONT: last_line = LINE_W'(V_FRONT - 1);
            default:  last_line = '0;
        endcase
    end

    // Next frame position: state, pixel-clock and line counters
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        line_d  = line_q;
        tp_d    = tp_q;
        if (state_q == S_IDLE) begin
            h_d    = '0;
            line_d = '0;
            if (EN) begin
                state_d = S_VSYNC;
                tp_d    = TEST_PAT;
            end
        end else if (h_q == H_W'(L - 1)) begin
            h_d = '0;
            if (line_q == last_line) begin
                line_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = S_VBACK;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    S_VFRONT: begin
                        if (EN) begin
                            state_d = S_VSYNC;
                            tp_d    = TEST_PAT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default:  state_d = S_IDLE;
                endcase
            end else begin
                line_d = line_q + LINE_W'(1);
            end
        end else begin
            h_d = h_q + H_W'(1);
        end
    end

    // Outputs for the next position: framing, pixel bytes and read address
    always_comb begin
        active_d  = (state_d == S_ACTIVE);
        col       = h_d >> 1;
        vsync_d   = (state_d == S_VSYNC);
        href_d    = active_d && (h_d < H_W'(HREF_LEN));
        done_d    = (state_d == S_VFRONT) && (h_d == H_W'(L - 1))
                    && (line_d == LINE_W'(V_FRONT - 1));
        pix_d     = pix_q;
        data_d    = '0;
        rd_addr_d = rd_addr_q;
        rgb       = rgb565(pix_q);

        if (href_d) begin
            if (!h_d[0]) begin
                pix_d  = tp_q ? (8'(col) + 8'(line_d)) : RD_DATA;
                rgb    = rgb565(pix_d);
                data_d = rgb[15:8];
            end else begin
                data_d = rgb[7:0];
            end
        end

        // Address of pixel col+1 during the two cycles before its byte 0
        if (active_d && (h_d < H_W'(HREF_LEN - 2))) begin
            rd_addr_d = ADDR_W'(32'(line_d) * H_ACTIVE + 32'(col) + 32'd1);
        end else if (h_d >= H_W'(L - 2)) begin
            // Pixel 0 of the next active line at the end of the blank interval
            if (active_d && (line_d < LINE_W'(V_ACTIVE - 1))) begin
                rd_addr_d = ADDR_W'((32'(line_d) + 32'd1) * H_ACTIVE);
            end else if ((state_d == S_VBACK) && (line_d == LINE_W'(V_BACK - 1))) begin
                rd_addr_d = '0;
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            line_q    <= '0;
            tp_q      <= 1'b0;
            pix_q     <= '0;
            data_q    <= '0;
            href_q    <= 1'b0;
            vsync_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            line_q    <= line_d;
            tp_q      <= tp_d;
            pix_q     <= pix_d;
            data_q    <= data_d;
            href_q    <= href_d;
            vsync_q   <= vsync_d;
            done_q    <= done_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign RD_ADDR    = rd_addr_q;
    assign DATA_OUT   = data_q;
    assign HREF_OUT   = href_q;
    assign VSYNC_OUT  = vsync_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_ov_frame_source.sv
// Bench for ov_frame_source: small frame geometry, RAM model, scoreboard of
// expected bytes/pixels/addresses checked by a negedge monitor.
module tb_ov_frame_source;

    localparam int unsigned H_ACTIVE    = 4;
    localparam int unsigned V_ACTIVE    = 2;
    localparam int unsigned H_BLANK     = 2;
    localparam int unsigned VSYNC_LINES = 3;
    localparam int unsigned V_BACK      = 2;
    localparam int unsigned V_FRONT     = 2;
    localparam int unsigned ADDR_W      = 4;
    localparam int L      = 2 * H_ACTIVE + H_BLANK;
    localparam int VS_CYC = VSYNC_LINES * L;
    localparam int ACT0   = (VSYNC_LINES + V_BACK) * L;
    localparam int F_CYC  = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * L;

    logic              pclk = 1'b0;
    logic              rst;
    logic              en;
    logic              tp;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'h00;
    logic [7:0]        data_out;
    logic              href;
    logic              vsync;
    logic              fdone;
    logic [7:0]        mem [0:7];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        exp_bytes [$];
    logic [7:0]        exp_pix   [$];
    logic [ADDR_W-1:0] exp_addr  [$];

    ov_frame_source #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .ADDR_W(ADDR_W)
    ) dut (
        .PCLK(pclk), .RESET(rst), .EN(en), .TEST_PAT(tp),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data), .DATA_OUT(data_out),
        .HREF_OUT(href), .VSYNC_OUT(vsync), .FRAME_DONE(fdone)
    );

    always #5 pclk = ~pclk;

    // Synchronous frame-buffer read port
    always @(posedge pclk) rd_data <= mem[rd_addr[2:0]];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp565(input logic [7:0] p);
        int r, g, b;
        r = int'(p[7:5]);
        g = int'(p[4:2]);
        b = int'(p[1:0]);
        return 16'((((r * 4) + (r / 2)) << 11) | (((g * 8) + g) << 5) | ((b * 8) + (b * 2) + (b / 2)));
    endfunction

    task automatic fill_mem(input logic [7:0] orv);
        for (int a = 0; a < 8; a++) mem[a] = 8'(a) | orv;
    endtask

    task automatic push_frame(input bit use_pat);
        for (int row = 0; row < int'(V_ACTIVE); row++) begin
            for (int col = 0; col < int'(H_ACTIVE); col++) begin
                logic [7:0]  px;
                logic [15:0] w;
                px = use_pat ? 8'(col + row) : mem[row * H_ACTIVE + col];
                w  = exp565(px);
                exp_bytes.push_back(w[15:8]);
                exp_bytes.push_back(w[7:0]);
                exp_pix.push_back(px);
                if (!use_pat) exp_addr.push_back(ADDR_W'(row * H_ACTIVE + col));
            end
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (k < 400) begin
            @(posedge pclk);
            #1;
            if (fdone) break;
            k++;
        end
        check(name, int'(fdone), 1);
    endtask

    // Monitor state
    int                p = 0;
    int                off;
    int                vs_cnt = 0;
    int                href_cnt = 0;
    int                frames_done = 0;
    bit                in_frame = 1'b0;
    bit                done_prev = 1'b0;
    bit                exp_vs_next = 1'b0;
    bit                e_vs, e_href, e_fd;
    logic [7:0]        b0_seen = 8'h00;
    logic [7:0]        pexp;
    logic [ADDR_W-1:0] aexp;
    logic [ADDR_W-1:0] hist1 = '0;
    logic [ADDR_W-1:0] hist2 = '0;

    // Frame timing checks and scoreboard pops, sampled on the falling edge
    always @(negedge pclk) begin
        if (rst) begin
            in_frame  = 1'b0;
            done_prev = 1'b0;
            p         = 0;
        end else begin
            if (done_prev) begin
                check("next_vsync", int'(vsync), int'(exp_vs_next));
                done_prev = 1'b0;
            end
            if (!in_frame && vsync) begin
                in_frame = 1'b1;
                p        = 0;
                vs_cnt   = 0;
                href_cnt = 0;
            end
            if (in_frame) begin
                off    = (p >= ACT0) ? ((p - ACT0) % L) : 0;
                e_vs   = (p < VS_CYC);
                e_href = (p >= ACT0) && (p < ACT0 + int'(V_ACTIVE) * L) && (off < 2 * int'(H_ACTIVE));
                e_fd   = (p == F_CYC - 1);
                check("vsync", int'(vsync), int'(e_vs));
                check("href", int'(href), int'(e_href));
                check("frame_done", int'(fdone), int'(e_fd));
                if (vsync) vs_cnt++;
                if (href) href_cnt++;
                if (href) begin
                    check("bytes_avail", int'(exp_bytes.size() > 0), 1);
                    if (exp_bytes.size() > 0) check("data", int'(data_out), int'(exp_bytes.pop_front()));
                    if ((off % 2) == 0) begin
                        b0_seen = data_out;
                        if (exp_addr.size() > 0) begin
                            aexp = exp_addr.pop_front();
                            check("rd_addr_m2", int'(hist2), int'(aexp));
                            check("rd_addr_m1", int'(hist1), int'(aexp));
                        end
                    end else begin
                        check("pix_avail", int'(exp_pix.size() > 0), 1);
                        if (exp_pix.size() > 0) begin
                            pexp = exp_pix.pop_front();
                            check("loopback_pix", int'({b0_seen[7:5], b0_seen[2:0], data_out[4:3]}), int'(pexp));
                        end
                    end
                end else begin
                    check("data_idle", int'(data_out), 0);
                end
                if (e_fd) begin
                    check("vsync_cycles", vs_cnt, VS_CYC);
                    check("href_cycles", href_cnt, 2 * int'(H_ACTIVE * V_ACTIVE));
                    frames_done++;
                    in_frame    = 1'b0;
                    done_prev   = 1'b1;
                    exp_vs_next = en;
                end
                p++;
            end else begin
                check("idle_href", int'(href), 0);
                check("idle_data", int'(data_out), 0);
                check("idle_done", int'(fdone), 0);
            end
        end
        hist2 = hist1;
        hist1 = rd_addr;
    end

    // Directed stimulus sequence
    initial begin
        int k;
        rst = 1'b1;
        en  = 1'b0;
        tp  = 1'b0;
        fill_mem(8'h00);
        repeat (3) @(posedge pclk);
        #1;
        check("rst_vsync", int'(vsync), 0);
        check("rst_href", int'(href), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_done", int'(fdone), 0);
        check("rst_addr", int'(rd_addr), 0);
        rst = 1'b0;
        repeat (2) @(posedge pclk);
        #1;

        // Frame A: test pattern
        en = 1'b1;
        tp = 1'b1;
        push_frame(1'b1);
        wait_done("frame_a_done");

        // Frame B: frame buffer, mem[a]=a
        tp = 1'b0;
        fill_mem(8'h00);
        push_frame(1'b0);
        wait_done("frame_b_done");

        // Frame C: frame buffer with bright pixels, address 7 holds 8'hFF
        fill_mem(8'hF8);
        push_frame(1'b0);
        wait_done("frame_c_done");

        // Frame D: test pattern, EN dropped during active line 1
        tp = 1'b1;
        push_frame(1'b1);
        repeat (65) @(posedge pclk);
        #1;
        en = 1'b0;
        wait_done("frame_d_done");
        repeat (40) @(posedge pclk);
        #1;
        check("frames_after_d", frames_done, 4);
        check("idle_vsync", int'(vsync), 0);

        // Frame E: interrupted by reset during an active line
        en = 1'b1;
        tp = 1'b0;
        fill_mem(8'h00);
        push_frame(1'b0);
        k = 0;
        while (k < 300 && !href) begin
            @(posedge pclk);
            #1;
            k++;
        end
        check("href_seen", int'(href), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_href", int'(href), 0);
        check("arst_data", int'(data_out), 0);
        check("arst_addr", int'(rd_addr), 0);
        check("arst_vsync", int'(vsync), 0);
        exp_bytes.delete();
        exp_pix.delete();
        exp_addr.delete();

        // Frame F: clean frame after reset release
        push_frame(1'b0);
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge pclk);
        #1;
        en = 1'b0;
        wait_done("frame_f_done");
        repeat (30) @(posedge pclk);
        #1;
        check("frames_total", frames_done, 5);
        check("bytes_left", exp_bytes.size(), 0);
        check("pix_left", exp_pix.size(), 0);
        check("addr_left", exp_addr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
